// File: rtl/vector_engine.sv
// Bresenham line rasteriser: draws one straight line into the display write path, one pixel per clock.
// Optional bounds clipping is enabled by defining VECTOR_ENGINE_CLIP_EN.
module vector_engine #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 400
) (
    input  logic        clock_in,
    input  logic        reset_n_in,
    input  logic        enable_in,
    input  logic [9:0]  x0_in,
    input  logic [9:0]  y0_in,
    input  logic [9:0]  x1_in,
    input  logic [9:0]  y1_in,
    input  logic [3:0]  color_index_in,
    input  logic        pixel_write_grant_in,
    output logic        pixel_write_enable_out,
    output logic [17:0] pixel_write_address_out,
    output logic [3:0]  pixel_write_data_out,
    output logic        busy_out,
    output logic        done_out
);

    // The whole visible frame must fit the 18-bit write address.
    if (SCREEN_WIDTH * SCREEN_HEIGHT > (1 << 18)) begin : g_size_check
        $error("vector_engine: frame does not fit an 18-bit address");
    end

    localparam logic [17:0] SW18 = 18'(SCREEN_WIDTH);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

    state_t             state_q;
    logic [9:0]         x0_q, y0_q, x1_q, y1_q;
    logic [3:0]         color_q;
    logic signed [11:0] dx_q, dy_q, err_q;
    logic               sx_neg_q, sy_neg_q;
    logic signed [10:0] x_q, y_q;
    logic               pres_q, last_q;
    logic               pwe_q, busy_q, done_q;
    logic [17:0]        addr_q;
    logic [3:0]         data_q;

    logic signed [11:0] xdiff, ydiff, dx_d, dy_d;
    logic signed [12:0] e2;
    logic               step_x, step_y;
    logic signed [11:0] err_d;
    logic signed [10:0] x_d, y_d;
    logic [17:0]        addr_d;
    logic               at_end, visible;

    always_comb begin
        xdiff  = signed'({2'b00, x1_q}) - signed'({2'b00, x0_q});
        ydiff  = signed'({2'b00, y1_q}) - signed'({2'b00, y0_q});
        dx_d   = xdiff[11] ? -xdiff : xdiff;
        dy_d   = ydiff[11] ? ydiff : -ydiff;

        // Both step decisions look at the error before this step's update.
        e2     = signed'({err_q, 1'b0});
        step_x = e2 >= signed'({dy_q[11], dy_q});
        step_y = e2 <= signed'({dx_q[11], dx_q});
        err_d  = err_q + (step_x ? dy_q : 12'sd0) + (step_y ? dx_q : 12'sd0);
        x_d    = x_q;
        y_d    = y_q;
        if (step_x) x_d = sx_neg_q ? x_q - 11'sd1 : x_q + 11'sd1;
        if (step_y) y_d = sy_neg_q ? y_q - 11'sd1 : y_q + 11'sd1;

        addr_d = {{7{y_q[10]}}, y_q} * SW18 + {{7{x_q[10]}}, x_q};
        at_end = (x_q == signed'({1'b0, x1_q})) && (y_q == signed'({1'b0, y1_q}));
`ifdef VECTOR_ENGINE_CLIP_EN
        visible = !x_q[10] && !y_q[10]
                  && ({22'd0, x_q[9:0]} < 32'(SCREEN_WIDTH))
                  && ({22'd0, y_q[9:0]} < 32'(SCREEN_HEIGHT));
`else
        visible = 1'b1;
`endif
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state_q <= IDLE;
            pwe_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pres_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (enable_in) begin
                        x0_q    <= x0_in;
                        y0_q    <= y0_in;
                        x1_q    <= x1_in;
                        y1_q    <= y1_in;
                        color_q <= color_index_in;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    dx_q     <= dx_d;
                    dy_q     <= dy_d;
                    err_q    <= dx_d + dy_d;
                    sx_neg_q <= !(x0_q < x1_q);
                    sy_neg_q <= !(y0_q < y1_q);
                    x_q      <= signed'({1'b0, x0_q});
                    y_q      <= signed'({1'b0, y0_q});
                    pres_q   <= 1'b0;
                    state_q  <= DRAW;
                end
                DRAW: begin
                    // A presented write waits for grant; skipped points never stall.
                    if (!(pwe_q && !pixel_write_grant_in)) begin
                        if (pres_q && last_q) begin
                            pwe_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pres_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            pres_q <= 1'b1;
                            last_q <= at_end;
                            pwe_q  <= visible;
                            addr_q <= addr_d;
                            data_q <= color_q;
                            x_q    <= x_d;
                            y_q    <= y_d;
                            err_q  <= err_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pixel_write_enable_out  = pwe_q;
    assign pixel_write_address_out = addr_q;
    assign pixel_write_data_out    = data_q;
    assign busy_out                = busy_q;
    assign done_out                = done_q;

endmodule

// File: tb/tb_vector_engine.sv
// Scoreboard bench for vector_engine: stimulus queues expected writes, a monitor pops them on each granted write.
module tb_vector_engine;

    logic        clock_in = 1'b0;
    logic        reset_n_in;
    logic        enable_in;
    logic [9:0]  x0_in, y0_in, x1_in, y1_in;
    logic [3:0]  color_index_in;
    logic        pixel_write_grant_in;
    logic        pixel_write_enable_out;
    logic [17:0] pixel_write_address_out;
    logic [3:0]  pixel_write_data_out;
    logic        busy_out;
    logic        done_out;

    vector_engine dut (
        .clock_in               (clock_in),
        .reset_n_in             (reset_n_in),
        .enable_in              (enable_in),
        .x0_in                  (x0_in),
        .y0_in                  (y0_in),
        .x1_in                  (x1_in),
        .y1_in                  (y1_in),
        .color_index_in         (color_index_in),
        .pixel_write_grant_in   (pixel_write_grant_in),
        .pixel_write_enable_out (pixel_write_enable_out),
        .pixel_write_address_out(pixel_write_address_out),
        .pixel_write_data_out   (pixel_write_data_out),
        .busy_out               (busy_out),
        .done_out               (done_out)
    );

    always #5 clock_in = ~clock_in;

    logic [21:0] exp_q[$];
    int pass_cnt = 0;
    int total_cnt = 0;
    int wr_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push(input int addr, input int col);
        exp_q.push_back({4'(col), 18'(addr)});
    endtask

    // Sample point: 1 time unit after the falling edge.
    task automatic sample();
        @(negedge clock_in);
        #1;
    endtask

    // Monitor: a write happens on any rising edge where enable and grant are both high.
    always begin
        logic [21:0] e;
        @(negedge clock_in);
        #3;
        if (pixel_write_enable_out && pixel_write_grant_in) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", int'(pixel_write_address_out), -1);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", int'(pixel_write_address_out), int'(e[17:0]));
                chk("wr_data", int'(pixel_write_data_out), int'(e[21:18]));
            end
        end
    end

    task automatic start(input int x0, input int y0, input int x1, input int y1, input int col);
        sample();
        #1;
        x0_in = 10'(x0); y0_in = 10'(y0); x1_in = 10'(x1); y1_in = 10'(y1);
        color_index_in = 4'(col);
        enable_in = 1'b1;
        sample();
        chk("busy_rise", int'(busy_out), 1);
        #1;
        enable_in = 1'b0;
    endtask

    // exp_done / exp_first < 0 skip that timing check (used around stalls).
    task automatic wait_done(input int exp_done, input int exp_first);
        int k = 0;
        int first = -1;
        bit seen = 0;
        while (k < 200 && !seen) begin
            sample();
            k++;
            if (pixel_write_enable_out && first < 0) first = k;
            if (done_out) seen = 1;
        end
        chk("done_seen", int'(seen), 1);
        if (exp_done >= 0) chk("done_cycle", k, exp_done);
        if (exp_first >= 0) chk("first_pixel_cycle", first, exp_first);
        chk("busy_at_done", int'(busy_out), 0);
        sample();
        chk("done_one_cycle", int'(done_out), 0);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0;
        int n;
        reset_n_in = 1'b0;
        enable_in = 1'b0;
        pixel_write_grant_in = 1'b1;
        x0_in = '0; y0_in = '0; x1_in = '0; y1_in = '0; color_index_in = '0;
        repeat (3) sample();
        chk("rst_we", int'(pixel_write_enable_out), 0);
        chk("rst_addr", int'(pixel_write_address_out), 0);
        chk("rst_data", int'(pixel_write_data_out), 0);
        chk("rst_busy", int'(busy_out), 0);
        chk("rst_done", int'(done_out), 0);
        #1 reset_n_in = 1'b1;

        // Horizontal (0,0)->(3,0)
        w0 = wr_cnt;
        push(0, 5); push(1, 5); push(2, 5); push(3, 5);
        start(0, 0, 3, 0, 5);
        wait_done(6, 2);
        chk("horiz_writes", wr_cnt - w0, 4);

        // Reversed horizontal
        push(3, 6); push(2, 6); push(1, 6); push(0, 6);
        start(3, 0, 0, 0, 6);
        wait_done(6, 2);

        // Diagonal
        push(6410, 7); push(7051, 7); push(7692, 7);
        start(10, 10, 12, 12, 7);
        wait_done(5, 2);

        // Steep
        push(0, 2); push(640, 2); push(1281, 2); push(1921, 2);
        start(0, 0, 1, 3, 2);
        wait_done(6, 2);

        // Degenerate single point
        w0 = wr_cnt;
        push(4487, 15);
        start(7, 7, 7, 7, 15);
        wait_done(3, 2);
        chk("degenerate_writes", wr_cnt - w0, 1);

        // Right-edge line: clipped with the macro, fully written without it
        w0 = wr_cnt;
        push(638, 4); push(639, 4);
`ifndef VECTOR_ENGINE_CLIP_EN
        push(640, 4); push(641, 4);
`endif
        start(638, 0, 641, 0, 4);
        wait_done(6, 2);
`ifdef VECTOR_ENGINE_CLIP_EN
        chk("clip_writes", wr_cnt - w0, 2);
`else
        chk("edge_writes", wr_cnt - w0, 4);
`endif

        // Stall: grant low for 3 cycles at the second pixel, enable pulse ignored
        w0 = wr_cnt;
        push(0, 5); push(1, 5); push(2, 5); push(3, 5);
        start(0, 0, 3, 0, 5);
        n = 0;
        while (n < 20 && !(pixel_write_enable_out && pixel_write_address_out == 18'd1)) begin
            sample();
            n++;
        end
        chk("stall_reached_pixel1", int'(n < 20), 1);
        #1;
        pixel_write_grant_in = 1'b0;
        enable_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("stall_hold_we", int'(pixel_write_enable_out), 1);
            chk("stall_hold_addr", int'(pixel_write_address_out), 1);
            #1 enable_in = 1'b0;
        end
        pixel_write_grant_in = 1'b1;
        wait_done(-1, -1);
        chk("stall_writes", wr_cnt - w0, 4);
        repeat (3) sample();
        chk("no_requeue_busy", int'(busy_out), 0);

        // Reset on the third pixel, then a fresh line
        push(0, 3); push(1, 3); push(2, 3);
        start(0, 0, 9, 0, 3);
        n = 0;
        while (n < 20 && !(pixel_write_enable_out && pixel_write_address_out == 18'd2)) begin
            sample();
            n++;
        end
        chk("reset_reached_pixel2", int'(n < 20), 1);
        #1 reset_n_in = 1'b0;
        sample();
        chk("mid_rst_we", int'(pixel_write_enable_out), 0);
        chk("mid_rst_addr", int'(pixel_write_address_out), 0);
        chk("mid_rst_data", int'(pixel_write_data_out), 0);
        chk("mid_rst_busy", int'(busy_out), 0);
        chk("mid_rst_done", int'(done_out), 0);
        chk("mid_rst_drained", exp_q.size(), 0);
        #1 reset_n_in = 1'b1;
        sample();
        chk("post_rst_idle", int'(busy_out), 0);
        push(645, 9); push(646, 9); push(647, 9);
        start(5, 1, 7, 1, 9);
        wait_done(5, 2);

        repeat (2) sample();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/vector_engine.md
# vector_engine

Rasterises single straight lines into the display write path, one pixel per clock. It uses integer Bresenham stepping and sits in the display clock domain as a peer of the sprite engine. Its pixel write outputs feed the graphics write mux, and through it the back display buffer. Line parameters come from SPI-domain registers, which are held stable while `busy_out` is high; the start pulse arrives through a pulse synchroniser.

## Interface
Parameters:
- `SCREEN_WIDTH`, 640, visible columns; also the row stride of the write address.
- `SCREEN_HEIGHT`, 400, visible rows.

Ports:
- `clock_in`  in  1  display clock.
- `reset_n_in`  in  1  reset; synchronous, active-low.
- `enable_in`  in  1  one-cycle start pulse; honoured only in IDLE.
- `x0_in`, `y0_in`  in  10 each  start point.
- `x1_in`, `y1_in`  in  10 each  end point.
- `color_index_in`  in  4  palette index written at every pixel.
- `pixel_write_grant_in`  in  1  high when no higher-priority source writes this cycle.
- `pixel_write_enable_out`  out  1  pixel write request.
- `pixel_write_address_out`  out  18  address = y*SCREEN_WIDTH + x.
- `pixel_write_data_out`  out  4  latched color index.
- `busy_out`  out  1  high from start acceptance until the line completes.
- `done_out`  out  1  one-cycle pulse on completion.

## Operation
- State machine: IDLE → SETUP → DRAW → IDLE.
- IDLE:
  - `enable_in`=1 latches x0/y0/x1/y1/color and moves to SETUP.
  - `busy_out` rises at the same edge.
- SETUP (1 cycle) computes:
  - dx = |x1−x0|; dy = −|y1−y0|.
  - sx = +1 if x0<x1, else −1; sy likewise from y0, y1.
  - err = dx+dy.
  - Current point (x,y) = (x0,y0).
- DRAW presents the current point each cycle, then steps with e2 = 2·err:
  - if e2 ≥ dy: err += dy, x += sx.
  - if e2 ≤ dx: err += dx, y += sy.
  - Both updates use the pre-update err.
- Arithmetic widths:
  - dx, dy, err: 12-bit signed.
  - e2: 13-bit signed.
  - x, y: 11-bit signed internally.
  - Address: (y<<9)+(y<<7)+x, truncated to 18 bits.
- Advance rule:
  - With a write request pending, the point advances only when `pixel_write_enable_out` & `pixel_write_grant_in`.
  - With grant low, all outputs and internal state hold.
- Completion:
  - The endpoint write is accepted, or the endpoint is skipped under clipping.
  - Next cycle: IDLE, `busy_out`=0, `done_out`=1 for one cycle.
- Degenerate line x0==x1, y0==y1: exactly one write.
- `enable_in` while busy is ignored; there is no queueing.
- Reset (any state, including mid-line):
  - State returns to IDLE the next edge.
  - All outputs go to 0; latched parameters are not cleared.

## Timing
- Reset values: `pixel_write_enable_out`=0, `pixel_write_address_out`=0, `pixel_write_data_out`=0, `busy_out`=0, `done_out`=0.
- Latency:
  - Edge E accepts the start pulse.
  - The first write request is valid in the cycle following edge E+2.
- Throughput: one pixel per cycle with grant held high.
- Total cycles for an N-point line with no stalls: 2 (accept to first pixel) + N, then `done_out`.
- All outputs are registered; `pixel_write_grant_in` is the only input used combinationally in the same cycle.

## Configuration
- `VECTOR_ENGINE_CLIP_EN` defined:
  - Points with x ≥ SCREEN_WIDTH, y ≥ SCREEN_HEIGHT, or negative coordinates are skipped: no write request, no grant needed.
  - A skipped point consumes one cycle and stepping continues.
- Undefined:
  - No bounds check; every point is written with the truncated address.
  - Callers must supply on-screen endpoints.

## Test plan
- Horizontal line (0,0)→(3,0), color 5, grant=1 → addresses 0,1,2,3 on four consecutive cycles, data 5, then `done_out` pulse and `busy_out`=0.
- Reversed horizontal line (3,0)→(0,0) → addresses 3,2,1,0; diagonal (10,10)→(12,12) → 6410, 7051, 7692.
- Steep line (0,0)→(1,3) → points (0,0),(0,1),(1,2),(1,3), i.e. addresses 0, 640, 1281, 1921.
- Line (0,0)→(3,0) with grant low for 3 cycles at the second pixel:
  - Address 1 and the enable are held throughout the stall.
  - Total writes = 4, none duplicated or dropped.
  - `enable_in` pulse during the line is ignored.
- With `VECTOR_ENGINE_CLIP_EN`, line (638,0)→(641,0):
  - Writes 638 and 639 only.
  - `done_out` 4 DRAW cycles after the first pixel.
  - Same line without the macro: four writes, addresses 638–641.
- Reset asserted on the third pixel of (0,0)→(9,0):
  - Next cycle: all outputs 0, state IDLE.
  - A new `enable_in` afterwards draws normally from its own start point.
